// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared codes for the motor command path: sequencer state
//               codes, driver command codes and pending-direction codes.
//               The motor driver decodes the same CMD_* values.
// Revision    : 1.0  initial release
// ============================================================================
package motor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UP    = 3'd1,
        ST_DOWN  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_UP   = 2'd1,
        PEND_DOWN = 2'd2
    } pend_t;

    // Driver command for a given sequencer state; only UP and DOWN drive
    // the motor, every other state holds the bus at CMD_NONE.
    function automatic logic [1:0] state_cmd(input state_t st);
        case (st)
            ST_UP:   state_cmd = CMD_UP;
            ST_DOWN: state_cmd = CMD_DOWN;
            default: state_cmd = CMD_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : motor_seq_timer
// Description : CNT_W-bit saturating cycle counter with dead-time and
//               travel-timeout terminal-count flags.
// Ports       : clk, reset (async, active-high)
//               clr          - synchronous clear (wins over en)
//               en           - count enable
//               count        - current count
//               dead_done    - count == DEAD_CYC-1
//               timeout_done - count == TIMEOUT_CYC-1
// Revision    : 1.0  initial release
// ============================================================================
module motor_seq_timer #(
    parameter int unsigned CNT_W       = 29,
    parameter int unsigned DEAD_CYC    = 1000000,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             dead_done,
    output logic             timeout_done
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            // Holds at all-ones rather than wrapping back to a small value.
            count <= count + 1'b1;
        end
    end

    assign dead_done    = (count == CNT_W'(DEAD_CYC - 1));
    assign timeout_done = (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : motor_cmd_sequencer
// Description : Converts up/down/stop request pulses into the motor driver
//               cmd bus, inserting dead time on every stop or reversal and
//               latching a fault on travel timeout or impossible limits.
// Ports       : clk, reset (async, active-high)
//               req_up / req_down / req_stop - single-cycle requests
//               TopeA_S / TopeB_S            - top / bottom limit status
//               cmd       - 00 none, 01 up, 10 down
//               busy      - in UP, DOWN or DEAD
//               at_top / at_bottom - registered limit copies
//               fault     - in FAULT
//               state_o   - current state code
// Revision    : 1.0  initial release
// ============================================================================
module motor_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int unsigned DEAD_CYC    = 1000000,
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned CNT_W       = 29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_up,
    input  logic       req_down,
    input  logic       req_stop,
    input  logic       TopeA_S,
    input  logic       TopeB_S,
    output logic [1:0] cmd,
    output logic       busy,
    output logic       at_top,
    output logic       at_bottom,
    output logic       fault,
    output logic [2:0] state_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    pend_t            r_pend;
    pend_t            w_pend_nxt;
    logic [CNT_W-1:0] w_timer;
    logic             w_dead_done;
    logic             w_timeout_done;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic             w_up;
    logic             w_dn;
    logic             w_sensor_fault;

    // A stop outranks everything and up+down together is a conflict, so a
    // direction request only counts when it arrives alone.
    assign w_up           = req_up   & ~req_down & ~req_stop;
    assign w_dn           = req_down & ~req_up   & ~req_stop;
    assign w_sensor_fault = TopeA_S & TopeB_S;

    // Timer restarts on every state entry and runs in the timed states.
    assign w_timer_clr = (w_state_nxt != r_state);
    assign w_timer_en  = (r_state == ST_UP) || (r_state == ST_DOWN) ||
                         (r_state == ST_DEAD);

    motor_seq_timer #(
        .CNT_W       (CNT_W),
        .DEAD_CYC    (DEAD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .clr          (w_timer_clr),
        .en           (w_timer_en),
        .count        (w_timer),
        .dead_done    (w_dead_done),
        .timeout_done (w_timeout_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        if (w_sensor_fault && (r_state != ST_FAULT)) begin
            // Both limits active cannot happen mechanically: treat as sensor fault.
            w_state_nxt = ST_FAULT;
            w_pend_nxt  = PEND_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_pend_nxt = PEND_NONE;
                    if (w_up && !TopeA_S) begin
                        w_state_nxt = ST_UP;
                    end else if (w_dn && !TopeB_S) begin
                        w_state_nxt = ST_DOWN;
                    end
                end
                ST_UP: begin
                    if (TopeA_S || req_stop) begin
                        w_state_nxt = ST_DEAD;
                        w_pend_nxt  = PEND_NONE;
                    end else if (w_dn) begin
                        w_state_nxt = ST_DEAD;
                        w_pend_nxt  = PEND_DOWN;
                    end else if (w_timeout_done) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
                ST_DOWN: begin
                    if (TopeB_S || req_stop) begin
                        w_state_nxt = ST_DEAD;
                        w_pend_nxt  = PEND_NONE;
                    end else if (w_up) begin
                        w_state_nxt = ST_DEAD;
                        w_pend_nxt  = PEND_UP;
                    end else if (w_timeout_done) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
                ST_DEAD: begin
                    // Requests during dead time retarget the pending move;
                    // one arriving on the final dead cycle still counts.
                    if (req_stop) begin
                        w_pend_nxt = PEND_NONE;
                    end else if (w_up) begin
                        w_pend_nxt = PEND_UP;
                    end else if (w_dn) begin
                        w_pend_nxt = PEND_DOWN;
                    end
                    if (w_dead_done) begin
                        if ((w_pend_nxt == PEND_UP) && !TopeA_S) begin
                            w_state_nxt = ST_UP;
                        end else if ((w_pend_nxt == PEND_DOWN) && !TopeB_S) begin
                            w_state_nxt = ST_DOWN;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                        w_pend_nxt = PEND_NONE;
                    end
                end
                ST_FAULT: begin
                    w_pend_nxt = PEND_NONE;
                    if (req_stop && !w_sensor_fault) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pend_nxt  = PEND_NONE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so cmd follows a request
    // or limit one edge after it is sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pend    <= PEND_NONE;
            cmd       <= CMD_NONE;
            busy      <= 1'b0;
            fault     <= 1'b0;
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            cmd       <= state_cmd(w_state_nxt);
            busy      <= (w_state_nxt == ST_UP) || (w_state_nxt == ST_DOWN) ||
                         (w_state_nxt == ST_DEAD);
            fault     <= (w_state_nxt == ST_FAULT);
            at_top    <= TopeA_S;
            at_bottom <= TopeB_S;
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_cmd_sequencer
// Description : Scoreboard bench for motor_cmd_sequencer. A driver applies
//               directed and random request/limit patterns, runs a
//               behavioural model and queues the expected outputs; a monitor
//               pops and compares one entry per clock.
// Revision    : 1.0  initial release
// ============================================================================
module tb_motor_cmd_sequencer;

    localparam int DEAD = 4;
    localparam int TMO  = 20;
    localparam int W    = 8;

    // Model modes use the documented state codes.
    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;
    localparam int M_DEAD  = 3;
    localparam int M_FAULT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_up = 1'b0;
    logic       req_down = 1'b0;
    logic       req_stop = 1'b0;
    logic       TopeA_S = 1'b0;
    logic       TopeB_S = 1'b0;
    logic [1:0] cmd;
    logic       busy;
    logic       at_top;
    logic       at_bottom;
    logic       fault;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    motor_cmd_sequencer #(
        .DEAD_CYC    (DEAD),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_up    (req_up),
        .req_down  (req_down),
        .req_stop  (req_stop),
        .TopeA_S   (TopeA_S),
        .TopeB_S   (TopeB_S),
        .cmd       (cmd),
        .busy      (busy),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .fault     (fault),
        .state_o   (state_o)
    );

    typedef struct packed {
        logic [1:0] cmd;
        logic       busy;
        logic       at_top;
        logic       at_bottom;
        logic       fault;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: direction, remaining dead cycles, cycles travelled.
    int   m_mode = M_IDLE;
    int   m_pend = 0;        // 0 none, 1 up, 2 down
    int   m_dead_left = 0;
    int   m_travel = 0;
    bit   lim_a = 1'b0;
    bit   lim_b = 1'b0;
    logic [1:0] prev_cmd = 2'b00;

    function automatic exp_t model_out(input int mode, input bit a, input bit b);
        exp_t e;
        e.cmd       = (mode == M_UP) ? 2'b01 : (mode == M_DOWN) ? 2'b10 : 2'b00;
        e.busy      = (mode == M_UP) || (mode == M_DOWN) || (mode == M_DEAD);
        e.at_top    = a;
        e.at_bottom = b;
        e.fault     = (mode == M_FAULT);
        e.st        = 3'(mode);
        return e;
    endfunction

    task automatic go_dead(input int pend);
        m_mode      = M_DEAD;
        m_pend      = pend;
        m_dead_left = DEAD;
    endtask

    task automatic go_move(input int mode);
        m_mode   = mode;
        m_travel = 0;
    endtask

    task automatic model_edge(input bit u, input bit d, input bit s, input bit a, input bit b);
        bit want_up;
        bit want_dn;
        want_up = u && !d && !s;
        want_dn = d && !u && !s;
        if (m_mode != M_FAULT && a && b) begin
            m_mode = M_FAULT;
            m_pend = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (want_up && !a)      go_move(M_UP);
                    else if (want_dn && !b) go_move(M_DOWN);
                end
                M_UP: begin
                    if (a || s)                 go_dead(0);
                    else if (want_dn)           go_dead(2);
                    else if (m_travel == TMO-1) m_mode = M_FAULT;
                    else                        m_travel++;
                end
                M_DOWN: begin
                    if (b || s)                 go_dead(0);
                    else if (want_up)           go_dead(1);
                    else if (m_travel == TMO-1) m_mode = M_FAULT;
                    else                        m_travel++;
                end
                M_DEAD: begin
                    if (s)            m_pend = 0;
                    else if (want_up) m_pend = 1;
                    else if (want_dn) m_pend = 2;
                    if (m_dead_left == 1) begin
                        if (m_pend == 1 && !a)      go_move(M_UP);
                        else if (m_pend == 2 && !b) go_move(M_DOWN);
                        else                        m_mode = M_IDLE;
                        m_pend = 0;
                    end else begin
                        m_dead_left--;
                    end
                end
                default: begin
                    if (s && !(a && b)) m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    // One clock of stimulus: inputs change 2 time units after the edge and
    // the expectation for the following edge is queued.
    task automatic step(input bit u, input bit d, input bit s, input bit r);
        @(posedge clk);
        #2;
        req_up   = u;
        req_down = d;
        req_stop = s;
        TopeA_S  = lim_a;
        TopeB_S  = lim_b;
        reset    = r;
        if (r) begin
            m_mode = M_IDLE;
            m_pend = 0;
            q.push_back(model_out(M_IDLE, 1'b0, 1'b0));
            #1;
            checks++;
            if (cmd !== 2'b00 || state_o !== 3'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL async_reset t=%0t got cmd=%b state=%0d busy=%b, expected cmd=00 state=0 busy=0",
                         $time, cmd, state_o, busy);
            end
        end else begin
            model_edge(u, d, s, lim_a, lim_b);
            q.push_back(model_out(m_mode, lim_a, lim_b));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one queued expectation per clock, plus a guard against a
    // direct 01<->10 reversal on the cmd bus.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {cmd, busy, at_top, at_bottom, fault, state_o};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got cmd=%b busy=%b top=%b bot=%b fault=%b state=%0d, expected cmd=%b busy=%b top=%b bot=%b fault=%b state=%0d",
                             $time, act.cmd, act.busy, act.at_top, act.at_bottom, act.fault, act.st,
                             e.cmd, e.busy, e.at_top, e.at_bottom, e.fault, e.st);
                end
                checks++;
                if ((prev_cmd == 2'b01 && cmd == 2'b10) || (prev_cmd == 2'b10 && cmd == 2'b01)) begin
                    errors++;
                    $display("FAIL reversal t=%0t cmd went %b -> %b, expected a 00 gap", $time, prev_cmd, cmd);
                end
                prev_cmd = cmd;
            end
        end
    end

    initial begin
        // Reset, move up, reach the top limit.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        lim_a = 1'b1;
        idle(8);

        // Down from the top, reverse to up mid-travel, then stop.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        lim_a = 1'b0;
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(7);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        // Request toward an active limit, and a conflicting request.
        lim_b = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        lim_b = 1'b0;
        idle(1);

        // Travel timeout, ignored request in FAULT, stop clears it.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(24);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Both limits during DOWN; stop refused until limits clear.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        lim_a = 1'b1;
        lim_b = 1'b1;
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        lim_a = 1'b0;
        lim_b = 1'b0;
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Reset mid-DOWN, and during DEAD with an up move pending.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Random traffic with sticky, mostly-exclusive limit sensors.
        for (int i = 0; i < 3000; i++) begin
            bit u;
            bit d;
            bit s;
            bit r;
            if (lim_a) lim_a = ($urandom_range(0, 5) != 0);
            else       lim_a = ($urandom_range(0, 29) == 0);
            if (lim_b) lim_b = ($urandom_range(0, 5) != 0);
            else       lim_b = ($urandom_range(0, 29) == 0);
            u = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 399) == 0);
            step(u, d, s, r);
        end

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Upstream controller for the existing motor driver.
- Turns user requests (up/down/stop pulses) into the driver's 2-bit `cmd` bus.
- Watches the driver's limit-status outputs (TopeA_S = top, TopeB_S = bottom).
- Inserts a dead time on every stop or reversal, and enforces a travel timeout that latches a fault.
- Sits between the button/command decoder and the Motor driver.

Parameters:
- DEAD_CYC, 1000000: cycles `cmd` is held at 00 after any stop or before any reversal (20 ms at 50 MHz).
- TIMEOUT_CYC, 500000000: maximum cycles in UP or DOWN before FAULT (10 s at 50 MHz).
- CNT_W, 29: timer width; must satisfy 2^CNT_W > max(DEAD_CYC, TIMEOUT_CYC).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- req_up  in  1  single-cycle request to move up (synchronous to clk).
- req_down  in  1  single-cycle request to move down.
- req_stop  in  1  single-cycle stop request; also clears FAULT.
- TopeA_S  in  1  top limit status from the driver, 1 = at top.
- TopeB_S  in  1  bottom limit status from the driver, 1 = at bottom.
- cmd  out  2  driver command: 00 none, 01 up, 10 down; 11 is never driven.
- busy  out  1  1 in UP, DOWN or DEAD.
- at_top  out  1  registered copy of TopeA_S.
- at_bottom  out  1  registered copy of TopeB_S.
- fault  out  1  1 while in FAULT.
- state_o  out  3  current state code, for debug/LEDs.

Behaviour:
- Clocking: all outputs are registered; reset is async active-high.
- Reset values: state IDLE, cmd=00, busy=0, at_top=0, at_bottom=0, fault=0, state_o=IDLE code, timer=0, pending=NONE.
- States (package codes): IDLE=0, UP=1, DOWN=2, DEAD=3, FAULT=4.
- Timer: one CNT_W counter, cleared on every state entry, increments each cycle in UP/DOWN/DEAD, saturates at all-ones.
- Latency: an input sampled at edge n is reflected in `cmd`/`state_o` after edge n. This gives one cycle from request or limit to `cmd` change.
- Request priority each cycle: req_stop > (req_up & req_down together, treated as a conflict and ignored) > single request.
- Global rule: TopeA_S & TopeB_S both 1 in any state other than FAULT -> FAULT next cycle (sensor fault). This has priority over everything except reset.
- IDLE, cmd=00:
  - req_up & !TopeA_S -> UP.
  - req_down & !TopeB_S -> DOWN.
  - A request toward an already-active limit is ignored.
  - req_stop is a no-op.
- UP, cmd=01:
  - TopeA_S=1 -> DEAD with pending=NONE.
  - req_stop -> DEAD, pending=NONE.
  - req_down -> DEAD, pending=DOWN.
  - req_up is ignored.
  - timer == TIMEOUT_CYC-1 with no limit seen -> FAULT.
  - TopeB_S going low while leaving the bottom is normal.
- DOWN, cmd=10: mirror of UP with TopeB_S and pending=UP.
- DEAD, cmd=00:
  - On entry the timer is cleared.
  - At timer == DEAD_CYC-1: go to the pending direction if its limit is inactive, else IDLE; pending is cleared.
  - During DEAD, req_up/req_down overwrite pending (last one wins) and req_stop sets pending=NONE.
  - A conflicting simultaneous up/down is ignored.
- FAULT, cmd=00, fault=1:
  - Exits only on req_stop while !(TopeA_S & TopeB_S) -> IDLE.
  - All other requests are ignored.
- Direction change: `cmd` never goes 01->10 or 10->01 directly; at least DEAD_CYC cycles of 00 separate them.
- Reset mid-motion: `cmd` drops to 00 asynchronously; no pending state survives.
- Limit on the same cycle as req_stop: both lead to DEAD with pending=NONE; the result is identical.
- busy = state in {UP, DOWN, DEAD}.
- at_top and at_bottom are updated every cycle.

Decomposition:
- Shared package motor_pkg holds:
  - state codes: ST_IDLE, ST_UP, ST_DOWN, ST_DEAD, ST_FAULT;
  - cmd codes: CMD_NONE=00, CMD_UP=01, CMD_DOWN=10;
  - pending-direction codes.
- The Motor driver uses the same cmd constants.
- One sub-module: motor_seq_timer, a CNT_W saturating counter.
  - Inputs: clr, en.
  - Outputs: count, dead_done, timeout_done.
- The FSM and pending register stay in the top module.

Test Plan:
All scenarios use DEAD_CYC=4, TIMEOUT_CYC=20.
- Reset then req_up at cycle 5, TopeA_S rises at cycle 12 -> cmd=01 from cycle 6, cmd=00 from cycle 13, DEAD 4 cycles, then IDLE, busy=0, at_top=1.
- While UP, pulse req_down -> cmd=00 for exactly 4 cycles, then cmd=10. No cycle has 01 immediately followed by 10.
- req_down while TopeB_S=1, and req_up & req_down in the same cycle -> cmd stays 00, state IDLE.
- req_up with no limit ever -> cmd=01 for 20 cycles, then FAULT, fault=1, cmd=00. req_up is ignored. req_stop -> IDLE, fault=0.
- TopeA_S=TopeB_S=1 during DOWN -> FAULT next cycle. req_stop with both still high -> stays FAULT. Limits cleared, then req_stop -> IDLE.
- Assert reset mid-DOWN and during DEAD with pending=UP -> cmd=00 immediately. After release, IDLE with no automatic motion.
